// File: rtl/sram64kb_ctrl_if.sv
// sram64kb_ctrl_if: request/response channels and array pins of the SRAM64KB sequencer
interface sram64kb_ctrl_if;
  logic        REQ0_VALID, REQ0_READY, REQ0_WE;
  logic [13:0] REQ0_ADDR;
  logic [7:0]  REQ0_WDATA;
  logic        REQ1_VALID, REQ1_READY, REQ1_WE;
  logic [13:0] REQ1_ADDR;
  logic [7:0]  REQ1_WDATA;
  logic        RSP0_VALID, RSP1_VALID;
  logic [7:0]  RSP0_RDATA, RSP1_RDATA;
  logic [9:0]  MEM_ADDR;
  logic        MEM_CE, MEM_WEB;
  logic [15:0] MEM_OEB, MEM_CSB;
  logic [7:0]  MEM_IDATA, MEM_ODATA;
  logic [3:0]  MEM_ODATA_SELECT;
  modport master (
    output REQ0_VALID, REQ0_WE, REQ0_ADDR, REQ0_WDATA,
    output REQ1_VALID, REQ1_WE, REQ1_ADDR, REQ1_WDATA, MEM_ODATA,
    input  REQ0_READY, REQ1_READY, RSP0_VALID, RSP1_VALID, RSP0_RDATA, RSP1_RDATA,
    input  MEM_ADDR, MEM_CE, MEM_WEB, MEM_OEB, MEM_CSB, MEM_IDATA, MEM_ODATA_SELECT
  );
  modport slave (
    input  REQ0_VALID, REQ0_WE, REQ0_ADDR, REQ0_WDATA,
    input  REQ1_VALID, REQ1_WE, REQ1_ADDR, REQ1_WDATA, MEM_ODATA,
    output REQ0_READY, REQ1_READY, RSP0_VALID, RSP1_VALID, RSP0_RDATA, RSP1_RDATA,
    output MEM_ADDR, MEM_CE, MEM_WEB, MEM_OEB, MEM_CSB, MEM_IDATA, MEM_ODATA_SELECT
  );
endinterface

// File: rtl/sram64kb_ctrl.sv
// sram64kb_ctrl: round-robin two-requester byte sequencer for the 16x1024x8 SRAM64KB array
module sram64kb_ctrl (
  input  logic          CLK,
  input  logic          RST,
  sram64kb_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, READ} state_t;
  state_t state_q, state_d;
  logic ptr_q, ptr_d, own_q, own_d, we_q, we_d;
  logic [13:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d, idata_q, idata_d;
  logic ce_q, ce_d, web_q, web_d;
  logic [15:0] csb_q, csb_d, oeb_q, oeb_d, bank_hot;
  logic [9:0] row_q, row_d;
  logic [3:0] sel_q, sel_d;
  logic [1:0] rsp_v_q, rsp_v_d;
  logic [1:0][7:0] rdata_q, rdata_d;
  logic g0, g1, busy;
  always_comb begin
    g0 = bus.REQ0_VALID & (~bus.REQ1_VALID | ~ptr_q);
    g1 = bus.REQ1_VALID & (~bus.REQ0_VALID | ptr_q);
    state_d = state_q;
    ptr_d = ptr_q;
    own_d = own_q;
    we_d = we_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rsp_v_d = '0;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (g0 | g1) begin
        state_d = SETUP;
        own_d = g1;
        we_d = g1 ? bus.REQ1_WE : bus.REQ0_WE;
        addr_d = g1 ? bus.REQ1_ADDR : bus.REQ0_ADDR;
        wdata_d = g1 ? bus.REQ1_WDATA : bus.REQ0_WDATA;
        // the pointer only moves when both requesters were contending
        ptr_d = (bus.REQ0_VALID & bus.REQ1_VALID) ? g0 : ptr_q;
      end
      SETUP: state_d = STROBE;
      STROBE: begin
        state_d = we_q ? IDLE : READ;
        rsp_v_d[own_q] = we_q;
        rdata_d[own_q] = we_q ? 8'h00 : rdata_q[own_q];
      end
      READ: begin
        state_d = IDLE;
        rsp_v_d[own_q] = 1'b1;
        rdata_d[own_q] = bus.MEM_ODATA;
      end
      default: state_d = IDLE;
    endcase
    // pins are registered, so they are derived from the state being entered
    busy = state_d != IDLE;
    bank_hot = 16'b1 << addr_d[13:10];
    row_d = busy ? addr_d[9:0] : '0;
    csb_d = busy ? ~bank_hot : '1;
    oeb_d = state_d == READ ? ~bank_hot : '1;
    web_d = ~(busy & we_d);
    idata_d = (busy & we_d) ? wdata_d : '0;
    sel_d = busy ? addr_d[13:10] : '0;
    ce_d = state_d == STROBE;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      ptr_q <= 1'b0;
      own_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      ce_q <= 1'b0;
      web_q <= 1'b1;
      csb_q <= '1;
      oeb_q <= '1;
      row_q <= '0;
      idata_q <= '0;
      sel_q <= '0;
      rsp_v_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      own_q <= own_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      ce_q <= ce_d;
      web_q <= web_d;
      csb_q <= csb_d;
      oeb_q <= oeb_d;
      row_q <= row_d;
      idata_q <= idata_d;
      sel_q <= sel_d;
      rsp_v_q <= rsp_v_d;
      rdata_q <= rdata_d;
    end
  end
  assign bus.REQ0_READY = (state_q == IDLE) & g0 & ~RST;
  assign bus.REQ1_READY = (state_q == IDLE) & g1 & ~RST;
  assign bus.RSP0_VALID = rsp_v_q[0];
  assign bus.RSP1_VALID = rsp_v_q[1];
  assign bus.RSP0_RDATA = rdata_q[0];
  assign bus.RSP1_RDATA = rdata_q[1];
  assign bus.MEM_ADDR = row_q;
  assign bus.MEM_CE = ce_q;
  assign bus.MEM_WEB = web_q;
  assign bus.MEM_CSB = csb_q;
  assign bus.MEM_OEB = oeb_q;
  assign bus.MEM_IDATA = idata_q;
  assign bus.MEM_ODATA_SELECT = sel_q;
endmodule

// File: tb/tb_sram64kb_ctrl.sv
// tb_sram64kb_ctrl: random and directed traffic against an array model and a cycle-level reference
module tb_sram64kb_ctrl;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  sram64kb_ctrl_if bus();
  sram64kb_ctrl dut (.CLK(CLK), .RST(RST), .bus(bus));
  always #5 CLK = ~CLK;
  localparam logic [55:0] PINS_RST = {10'h0, 1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 8'h00, 4'h0};
  typedef struct {int c; logic [7:0] d;} rsp_t;
  int total = 0, bad = 0, cyc = 0, ce_cnt = 0;
  logic [7:0] arr [16384];
  logic [7:0] ref_mem [16384];
  logic [7:0] dout [16];
  logic [55:0] pins, ep;
  logic [15:0] hot;
  logic [13:0] idx, t_addr;
  logic [7:0] t_wd;
  rsp_t q0[$], q1[$], r;
  bit run = 0, t_act = 0, t_we = 0, ptr = 0, e0, e1, v0, v1;
  int t_acc = 0, free_at = 0, ph;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  assign pins = {bus.MEM_ADDR, bus.MEM_CE, bus.MEM_WEB, bus.MEM_CSB, bus.MEM_OEB, bus.MEM_IDATA, bus.MEM_ODATA_SELECT};
  assign bus.MEM_ODATA = bus.MEM_OEB[bus.MEM_ODATA_SELECT] ? 8'h00 : dout[bus.MEM_ODATA_SELECT];
  // the array itself: an access happens on each rising MEM_CE
  always @(posedge bus.MEM_CE) begin
    ce_cnt++;
    for (int b = 0; b < 16; b++)
      if (!bus.MEM_CSB[b]) begin
        idx = {4'(b), bus.MEM_ADDR};
        if (!bus.MEM_WEB) arr[idx] = bus.MEM_IDATA;
        else dout[b] = arr[idx];
      end
  end
  always @(posedge CLK) cyc++;
  // reference: one transaction at a time, fixed phase timeline from the accept cycle
  always @(negedge CLK) begin
    if (run) begin
      ph = cyc - t_acc;
      hot = 16'b1 << t_addr[13:10];
      if (t_act && (ph == 1 || ph == 2 || (ph == 3 && !t_we)))
        ep = {t_addr[9:0], ph == 2, ~t_we, ~hot, ph == 3 ? ~hot : 16'hFFFF, t_we ? t_wd : 8'h00, t_addr[13:10]};
      else
        ep = PINS_RST;
      check("pins", pins, ep);
      e0 = q0.size() > 0 && q0[0].c == cyc;
      check("rsp0_valid", bus.RSP0_VALID, e0);
      if (e0) begin
        check("rsp0_rdata", bus.RSP0_RDATA, q0[0].d);
        void'(q0.pop_front());
      end
      e1 = q1.size() > 0 && q1[0].c == cyc;
      check("rsp1_valid", bus.RSP1_VALID, e1);
      if (e1) begin
        check("rsp1_rdata", bus.RSP1_RDATA, q1[0].d);
        void'(q1.pop_front());
      end
      v0 = bus.REQ0_VALID;
      v1 = bus.REQ1_VALID;
      e0 = !RST && cyc >= free_at && v0 && (!v1 || !ptr);
      e1 = !RST && cyc >= free_at && v1 && (!v0 || ptr);
      check("ready0", bus.REQ0_READY, e0);
      check("ready1", bus.REQ1_READY, e1);
      if (e0 || e1) begin
        t_act = 1;
        t_acc = cyc;
        t_we = e1 ? bus.REQ1_WE : bus.REQ0_WE;
        t_addr = e1 ? bus.REQ1_ADDR : bus.REQ0_ADDR;
        t_wd = e1 ? bus.REQ1_WDATA : bus.REQ0_WDATA;
        free_at = cyc + (t_we ? 3 : 4);
        if (v0 && v1) ptr = e0;
        r.c = free_at;
        r.d = t_we ? 8'h00 : ref_mem[t_addr];
        if (t_we) ref_mem[t_addr] = t_wd;
        if (e1) q1.push_back(r);
        else q0.push_back(r);
      end
    end
    if (RST) begin
      run = 1;
      t_act = 0;
      q0.delete();
      q1.delete();
      ptr = 0;
      free_at = cyc + 1;
    end
  end
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask
  // present a request, hold it until accepted, drop VALID after the accept edge
  task automatic req(input bit n, input bit we, input logic [13:0] a, input logic [7:0] d);
    bit done = 0;
    if (n) begin
      bus.REQ1_WE = we; bus.REQ1_ADDR = a; bus.REQ1_WDATA = d; bus.REQ1_VALID = 1;
    end else begin
      bus.REQ0_WE = we; bus.REQ0_ADDR = a; bus.REQ0_WDATA = d; bus.REQ0_VALID = 1;
    end
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge CLK);
      done = n ? bus.REQ1_READY : bus.REQ0_READY;
    end
    if (!done) check("req_timeout", 0, 1);
    @(posedge CLK);
    #1;
    if (n) bus.REQ1_VALID = 0;
    else bus.REQ0_VALID = 0;
  endtask
  initial begin
    logic [13:0] a;
    for (int i = 0; i < 16384; i++) begin
      arr[i] = 8'($urandom);
      ref_mem[i] = arr[i];
    end
    for (int i = 0; i < 16; i++) dout[i] = 8'h00;
    bus.REQ0_VALID = 1; bus.REQ0_WE = 1; bus.REQ0_ADDR = 14'h0123; bus.REQ0_WDATA = 8'h11;
    bus.REQ1_VALID = 1; bus.REQ1_WE = 0; bus.REQ1_ADDR = 14'h3FFF; bus.REQ1_WDATA = 8'h22;
    wait_cyc(3);
    check("ce_in_reset", ce_cnt, 0);
    check("reset_pins", pins, PINS_RST);
    check("reset_ready", {bus.REQ0_READY, bus.REQ1_READY}, 0);
    check("reset_rsp", {bus.RSP0_VALID, bus.RSP1_VALID, bus.RSP0_RDATA, bus.RSP1_RDATA}, 0);
    bus.REQ0_VALID = 0;
    bus.REQ1_VALID = 0;
    RST = 0;
    wait_cyc(2);
    req(0, 1, 14'h2C05, 8'h5A);
    check("w_setup", {bus.MEM_ADDR, bus.MEM_CSB, bus.MEM_WEB, bus.MEM_CE}, {10'h005, 16'hF7FF, 1'b0, 1'b0});
    wait_cyc(1);
    check("w_strobe_ce", bus.MEM_CE, 1);
    wait_cyc(1);
    check("w_rsp", bus.RSP0_VALID, 1);
    wait_cyc(2);
    req(1, 0, 14'h2C05, 8'h00);
    check("r_setup", {bus.MEM_ODATA_SELECT, bus.MEM_OEB}, {4'hB, 16'hFFFF});
    wait_cyc(1);
    check("r_strobe_oeb", bus.MEM_OEB, 16'hFFFF);
    wait_cyc(1);
    check("r_read_oeb", bus.MEM_OEB, 16'hF7FF);
    wait_cyc(1);
    check("r_rsp", {bus.RSP1_VALID, bus.RSP1_RDATA}, {1'b1, 8'h5A});
    wait_cyc(2);
    fork
      for (int i = 0; i < 4; i++) req(0, 0, {4'h0, 10'($urandom)}, 8'h00);
      for (int j = 0; j < 4; j++) req(1, 0, {4'hF, 10'($urandom)}, 8'h00);
    join
    wait_cyc(6);
    for (int b = 0; b < 16; b++)
      for (int k = 0; k < 2; k++) begin
        a = {4'(b), k ? 10'h3FF : 10'h000};
        req(1'($urandom), 1, a, a[7:0] ^ 8'hA5);
      end
    for (int b = 0; b < 16; b++)
      for (int k = 0; k < 2; k++) begin
        a = {4'(b), k ? 10'h3FF : 10'h000};
        req(1'($urandom), 0, a, 8'h00);
      end
    wait_cyc(6);
    req(0, 0, 14'h2C05, 8'h00);
    wait_cyc(1);
    RST = 1;
    wait_cyc(1);
    RST = 0;
    check("abort_pins", pins, PINS_RST);
    check("abort_rsp", {bus.RSP0_VALID, bus.RSP1_VALID}, 0);
    wait_cyc(4);
    req(1, 0, 14'h2C05, 8'h00);
    wait_cyc(3);
    check("reread", {bus.RSP1_VALID, bus.RSP1_RDATA}, {1'b1, 8'h5A});
    wait_cyc(2);
    fork
      for (int i = 0; i < 25; i++) begin
        req(0, 1'($urandom), {4'($urandom), 10'($urandom_range(0, 7))}, 8'($urandom));
        repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
      end
      for (int j = 0; j < 25; j++) begin
        req(1, 1'($urandom), {4'($urandom), 10'($urandom_range(0, 7))}, 8'($urandom));
        repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
      end
    join
    wait_cyc(8);
    check("drain", q0.size() + q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
